// File: rtl/req_shaper_pkg.sv
// rtl/req_shaper_pkg.sv - channel state type and default parameters for req_shaper
package req_shaper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    REL  = 2'd3
  } state_e;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_TMO   = 15;

endpackage

// File: rtl/req_chan.sv
// rtl/req_chan.sv - one shaper channel: token FIFO, request/hold FSM, wait-stall counter
module req_chan
  import req_shaper_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int TMO   = DEF_TMO
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [LEN_W-1:0] in_len_i,
  output logic             in_ready_o,
  input  logic             gnt_i,
  output logic             req_o,
  output logic             done_o,
  output logic             stall_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TMO + 1);

  logic [LEN_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             stall_q, stall_d;
  logic             push, pop;

  // Ready comes from the registered count only, so a pop never frees a slot in the same cycle.
  assign in_ready_o = (count_q < CW'(DEPTH));
  assign push       = in_valid_i & in_ready_o;
  assign done_o     = pop;
  assign stall_o    = stall_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_len_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    stall_d = stall_q;
    req_o   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = REQ;
          wait_d  = '0;
        end
      end
      REQ: begin
        req_o = 1'b1;
        if (gnt_i) begin
          state_d = HOLD;
          cnt_d   = mem_q[rd_ptr_q];
        end else if (wait_q < WW'(TMO)) begin
          wait_d = wait_q + 1'b1;
          if (wait_q == WW'(TMO - 1)) stall_d = 1'b1;
        end
      end
      HOLD: begin
        // A revoked grant is deliberately ignored here; the hold always runs to completion.
        req_o = 1'b1;
        if (cnt_q == '0) begin
          pop     = 1'b1;
          state_d = REL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      REL: begin
        if (!gnt_i) begin
          state_d = (count_q != '0) ? REQ : IDLE;
          wait_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/req_shaper.sv
// rtl/req_shaper.sv - two independent token-shaped request channels toward a two-requester arbiter
module req_shaper
  import req_shaper_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int TMO   = DEF_TMO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_0,
  input  logic             in_valid_1,
  input  logic [LEN_W-1:0] in_len_0,
  input  logic [LEN_W-1:0] in_len_1,
  output logic             in_ready_0,
  output logic             in_ready_1,
  input  logic             gnt_0,
  input  logic             gnt_1,
  output logic             req_0,
  output logic             req_1,
  output logic             done_0,
  output logic             done_1,
  output logic             stall_0,
  output logic             stall_1
);

  req_chan #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TMO(TMO)) u_chan_0 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid_0),
    .in_len_i   (in_len_0),
    .in_ready_o (in_ready_0),
    .gnt_i      (gnt_0),
    .req_o      (req_0),
    .done_o     (done_0),
    .stall_o    (stall_0)
  );

  req_chan #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TMO(TMO)) u_chan_1 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid_1),
    .in_len_i   (in_len_1),
    .in_ready_o (in_ready_1),
    .gnt_i      (gnt_1),
    .req_o      (req_1),
    .done_o     (done_1),
    .stall_o    (stall_1)
  );

endmodule

// File: doc/req_shaper.md
REQ_SHAPER -- requirements
Module: req_shaper

Interface
REQ-001 Parameter DEPTH, default 4; per-channel token FIFO depth, power of two, at least 2.
REQ-002 Parameter LEN_W, default 4; width of the hold-length field.
REQ-003 Parameter TMO, default 15; number of REQ-state cycles without a grant before the stall flag sets.
REQ-004 Port clk  in  1  single clock; all state updates occur on its rising edge.
REQ-005 Port rst_n  in  1  reset, synchronous and active-low.
REQ-006 Port in_valid_0 / in_valid_1  in  1  upstream token offer, per channel.
REQ-007 Port in_len_0 / in_len_1  in  LEN_W  hold length of the offered token, in cycles minus one.
REQ-008 Port in_ready_0 / in_ready_1  out  1  channel FIFO not full.
REQ-009 Port gnt_0 / gnt_1  in  1  registered grants from the two-requester arbiter.
REQ-010 Port req_0 / req_1  out  1  requests to the arbiter.
REQ-011 Port done_0 / done_1  out  1  one-cycle pulse when a token completes.
REQ-012 Port stall_0 / stall_1  out  1  sticky flag: request waited TMO cycles without a grant.

Function
REQ-013 Each channel SHALL operate independently; channel 1 is channel 0 with indices swapped.
REQ-014 A token SHALL be pushed on any cycle with in_valid_x=1 and in_ready_x=1; in_ready_x SHALL equal "FIFO count < DEPTH", derived from registered count only.
REQ-015 A pop on the same cycle as a push into a full FIFO SHALL NOT enable that push; ready recovers the following cycle.
REQ-016 The channel FSM SHALL have four states: IDLE, REQ, HOLD, REL.
REQ-017 IDLE: req_x=0; go to REQ when the FIFO is non-empty.
REQ-018 REQ: req_x=1; when gnt_x=1 is sampled, go to HOLD and load cnt with the head token's in_len.
REQ-019 HOLD: req_x=1; cnt decrements each cycle; when cnt==0, pop the head, pulse done_x, go to REL; len 0 gives exactly one HOLD cycle.
REQ-020 REL: req_x=0; stay until gnt_x=0 is sampled, then go to REQ if the FIFO is non-empty, else IDLE.
REQ-021 A gnt_x=0 in HOLD (grant revoked) SHALL be ignored; the countdown continues.
REQ-022 The wait counter SHALL count cycles in REQ, saturating at TMO; on reaching TMO, stall_x SHALL set and hold until reset; req_x remains asserted.
REQ-023 The wait counter SHALL clear on each entry to REQ.
REQ-024 The FIFO read and write pointers SHALL wrap modulo DEPTH; count SHALL be a separate register of width clog2(DEPTH)+1.

Reset
REQ-025 While rst_n=0 at a clock edge: state=IDLE, FIFO empty, cnt=0, wait counter=0.
REQ-026 During that reset: req_x=0, done_x=0, stall_x=0, in_ready_x=1.
REQ-027 Reset asserted mid-token SHALL discard all queued tokens, with no done pulse.

Structure
REQ-028 Package req_shaper_pkg SHALL hold the state enum (IDLE, REQ, HOLD, REL) and the default DEPTH, LEN_W and TMO constants.
REQ-029 One sub-module, req_chan (FIFO + FSM + counters), SHALL be instantiated twice by req_shaper.

Verification
REQ-030 Reset, then a single token len=2 on channel 0, with the arbiter granting 1 cycle after req -> req_0 high for 1+3 cycles, done_0 pulses once, then req_0=0.
REQ-031 Push 4 tokens on channel 0 with no grant -> in_ready_0=0 after the 4th; a 5th offer is not accepted; req_0 stays high.
REQ-032 Hold gnt_1=0 for 20 cycles with a token pending on channel 1 -> stall_1 sets on the 15th REQ cycle and stays set; req_1 stays 1.
REQ-033 Connect the arbiter; both channels load a len=0 token in the same cycle -> both complete, done_0 and done_1 pulse once each, no protocol hang.
REQ-034 Assert rst_n=0 while channel 0 is in HOLD with 3 tokens queued -> next cycle req_0=0, in_ready_0=1, no done_0; FIFO empty afterward.
REQ-035 Keep gnt_0 high for 5 cycles after REL entry -> req_0 stays 0 through REL; the next token's REQ starts only after gnt_0 falls.
